// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle for the iterative M-extension unit
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, funct3, srcA, srcB,
        input  busy, valid, result
    );

    modport slave (
        input  start, kill, funct3, srcA, srcB,
        output busy, valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative one-bit-per-cycle RISC-V M-extension multiply/divide unit
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    // Shared datapath register: multiply keeps {hi, lo} of the product,
    // divide keeps {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   bmag_q, bmag_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    logic              a_signed, b_signed;
    logic              in_a_neg, in_b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        acc_d    = acc_q;
        bmag_d   = bmag_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        // Operand decode for a request presented this cycle.
        a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        in_a_neg = a_signed && bus.srcA[XLEN-1];
        in_b_neg = b_signed && bus.srcB[XLEN-1];
        a_mag    = in_a_neg ? -bus.srcA : bus.srcA;
        b_mag    = in_b_neg ? -bus.srcB : bus.srcB;
        div_zero = bus.funct3[2] && (bus.srcB == '0);
        div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                   (bus.srcA == MIN_INT) && (bus.srcB == '1);

        // Multiply step: conditionally add the multiplicand into the high half;
        // the carry is kept by shifting the XLEN+1-bit sum back into the accumulator.
        add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
        // Divide step: bring the next dividend bit into the remainder and trial subtract.
        shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        trial   = shifted - {1'b0, bmag_q};

        prod = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quot = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.kill) begin
                    op_d    = bus.funct3;
                    a_neg_d = in_a_neg;
                    b_neg_d = in_b_neg;
                    bmag_d  = b_mag;
                    cnt_d   = CW'(XLEN - 1);
                    if (div_zero) begin
                        result_d = bus.funct3[1] ? bus.srcA : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = bus.funct3[1] ? '0 : bus.srcA;
                        state_d  = S_DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else begin
                    if (!op_q[2]) begin
                        acc_d = {add_sum, acc_q[XLEN-1:1]};
                    end else if (!trial[XLEN]) begin
                        acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else begin
                    case (op_q)
                        3'b000:                 result_d = prod[XLEN-1:0];
                        3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
                        3'b100, 3'b101:         result_d = quot;
                        default:                result_d = rem;
                    endcase
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_d  = (state_d != S_IDLE);
    assign valid_d = (state_d == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            acc_q    <= '0;
            bmag_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            acc_q    <= acc_d;
            bmag_q   <= bmag_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;
endmodule
